// File: rtl/pm_pkg.sv
// Shared definitions for the power-monitor channel scanner.
// Contents: FSM state type and encodings, channel/frame geometry, the status
// register address and a helper that packs the status word.
// The scanner's optional undervoltage kill feature is enabled by defining
// PM_SCAN_KILL_EN. This package is the same in both builds.
package pm_pkg;

  localparam int PM_NUM_CHAN   = 8;
  localparam int PM_FRAME_BITS = 16;
  localparam logic [3:0] PM_STATUS_ADDR = 4'd8;

  typedef logic [1:0] pm_state_t;
  localparam pm_state_t ST_IDLE   = 2'd0;
  localparam pm_state_t ST_SETTLE = 2'd1;
  localparam pm_state_t ST_SHIFT  = 2'd2;
  localparam pm_state_t ST_STORE  = 2'd3;

  // The status fields occupy 17 bits:
  // [16:9] scan_count, [8:6] zero, [5:3] chan, [2] busy, [1] error, [0] kill_sw.
  // The upper 15 bits of the 32-bit word are zero.
  function automatic logic [31:0] pm_status_word(input logic [7:0] scan_count,
                                                 input logic [2:0] chan,
                                                 input logic       busy,
                                                 input logic       error,
                                                 input logic       kill_sw);
    return {15'h0, scan_count, 3'b000, chan, busy, error, kill_sw};
  endfunction

endpackage

// File: rtl/pm_bit_timer.sv
// Serial bit timer for the power-monitor scanner.
// Generates the serial clock phase and the sample strobe while enabled.
// The phase counter restarts at 0 on the first enabled clock.
// Ports:
//   clk, reset - system clock and synchronous active-high reset
//   en         - high while the scanner is shifting a frame
//   sclk       - low for the first BIT_DIV/2 clocks of a bit, high for the rest
//   sample     - asserted on the clock edge at which sclk goes high
//   bit_end    - asserted on the last clock of each bit period
module pm_bit_timer #(
  parameter int BIT_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic sample,
  output logic bit_end
);

  localparam int HALF = BIT_DIV / 2;
  localparam int CW   = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

  logic [CW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (!en)
      phase_d = '0;
    else if (phase_q == CW'(BIT_DIV - 1))
      phase_d = '0;
    else
      phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      phase_q <= '0;
    else
      phase_q <= phase_d;
  end

  assign sclk    = en && (phase_q >= CW'(HALF));
  // The edge that ends phase HALF-1 is the edge where sclk rises.
  assign sample  = en && (phase_q == CW'(HALF - 1));
  assign bit_end = en && (phase_q == CW'(BIT_DIV - 1));

endmodule

// File: rtl/pm_channel_scanner.sv
// Power-monitor channel scanner.
// Steps through 8 mux channels. For each channel it waits for the analog
// path to settle, shifts in a 16-bit serial frame MSB first and stores it.
// The results are exposed on an Avalon slave with a registered read port.
// Optional feature: define PM_SCAN_KILL_EN to drive kill_sw from the
// channel-0 (main battery) undervoltage comparison. Without it, kill_sw is
// tied to 0.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   start                           - level-sensitive scan enable
//   data                            - serial bit from the power board
//   chipselect, read, address       - Avalon read request
//   readdata                        - registered read data, 1-cycle latency
//   mux                             - channel select
//   sclk                            - serial clock
//   kill_sw, error, busy            - status outputs
import pm_pkg::*;

module pm_channel_scanner #(
  parameter int          SETTLE_CYCLES = 64,
  parameter int          BIT_DIV       = 16,
  parameter logic [15:0] UNDERVOLT     = 16'h0A00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        data,
  input  logic        chipselect,
  input  logic        read,
  input  logic [3:0]  address,
  output logic [31:0] readdata,
  output logic [2:0]  mux,
  output logic        sclk,
  output logic        kill_sw,
  output logic        error,
  output logic        busy
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  pm_state_t                 state_q, state_d;
  logic [2:0]                chan_q, chan_d;
  logic [2:0]                mux_q, mux_d;
  logic [SW-1:0]             settle_q, settle_d;
  logic [3:0]                bitcnt_q, bitcnt_d;
  logic [PM_FRAME_BITS-1:0]  shift_q, shift_d;
  logic [PM_FRAME_BITS-1:0]  chan_reg_q [PM_NUM_CHAN];
  logic [PM_FRAME_BITS-1:0]  chan_reg_d [PM_NUM_CHAN];
  logic [7:0]                scan_count_q, scan_count_d;
  logic                      error_q, error_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_set, status_rd;
  logic                      sample, bit_end;

  pm_bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (state_q == ST_SHIFT),
    .sclk    (sclk),
    .sample  (sample),
    .bit_end (bit_end)
  );

  assign busy     = (state_q != ST_IDLE);
  assign mux      = mux_q;
  assign error    = error_q;
  assign readdata = rdata_q;

  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    mux_d        = mux_q;
    settle_d     = settle_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    chan_reg_d   = chan_reg_q;
    scan_count_d = scan_count_q;
    err_set      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SETTLE;
          mux_d    = chan_q;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d  = ST_SHIFT;
          bitcnt_d = 4'(PM_FRAME_BITS - 1);
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sample)
          shift_d = {shift_q[PM_FRAME_BITS-2:0], data};
        if (bit_end) begin
          if (bitcnt_q == '0)
            state_d = ST_STORE;
          else
            bitcnt_d = bitcnt_q - 1'b1;
        end
      end
      ST_STORE: begin
        chan_reg_d[chan_q] = shift_q;
        err_set            = shift_q[PM_FRAME_BITS-1];
        chan_d             = chan_q + 1'b1;
        // The mux follows the next channel even when the scan stops here.
        mux_d              = chan_q + 1'b1;
        if (chan_q == 3'd7)
          scan_count_d = scan_count_q + 1'b1;
        if (start) begin
          state_d  = ST_SETTLE;
          settle_d = SW'(SETTLE_CYCLES - 1);
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: a status read clears it, but a new error on the same clock wins.
  always_comb begin
    status_rd = chipselect && read && (address == PM_STATUS_ADDR);
    error_d   = error_q;
    if (err_set)
      error_d = 1'b1;
    else if (status_rd)
      error_d = 1'b0;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (chipselect && read) begin
      if (!address[3])
        rdata_d = {16'h0, chan_reg_q[address[2:0]]};
      else if (address == PM_STATUS_ADDR)
        rdata_d = pm_status_word(scan_count_q, chan_q, busy, error_q, kill_sw);
      else
        rdata_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      mux_q        <= '0;
      settle_q     <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      scan_count_q <= '0;
      error_q      <= 1'b0;
      rdata_q      <= '0;
      for (int i = 0; i < PM_NUM_CHAN; i++)
        chan_reg_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      mux_q        <= mux_d;
      settle_q     <= settle_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      scan_count_q <= scan_count_d;
      error_q      <= error_d;
      rdata_q      <= rdata_d;
      for (int i = 0; i < PM_NUM_CHAN; i++)
        chan_reg_q[i] <= chan_reg_d[i];
    end
  end

`ifdef PM_SCAN_KILL_EN
  logic kill_q, kill_d;

  // Only a completed channel-0 frame may move the kill switch.
  always_comb begin
    kill_d = kill_q;
    if ((state_q == ST_STORE) && (chan_q == 3'd0))
      kill_d = (shift_q[14:0] < UNDERVOLT[14:0]);
  end

  always_ff @(posedge clk) begin
    if (reset)
      kill_q <= 1'b0;
    else
      kill_q <= kill_d;
  end

  assign kill_sw = kill_q;
`else
  assign kill_sw = 1'b0;
`endif

endmodule

// File: tb/tb_pm_channel_scanner.sv
module tb_pm_channel_scanner;

  localparam int SETTLE = 4;
  localparam int BDIV   = 4;
`ifdef PM_SCAN_KILL_EN
  localparam logic KILL = 1'b1;
`else
  localparam logic KILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, data, chipselect, read;
  logic [3:0]  address;
  logic [31:0] readdata;
  logic [2:0]  mux;
  logic        sclk, kill_sw, error, busy;

  always #5 clk = ~clk;

  pm_channel_scanner #(.SETTLE_CYCLES(SETTLE), .BIT_DIV(BDIV), .UNDERVOLT(16'h0A00)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .chipselect(chipselect), .read(read), .address(address), .readdata(readdata),
    .mux(mux), .sclk(sclk), .kill_sw(kill_sw), .error(error), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [15:0] frames[8];
  int   idx = 0, rises = 0, stores = 0;
  logic sclk_prev = 1'b0;
  logic [2:0] mux_prev = 3'd0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] stat(input logic [7:0] sc, input logic [2:0] ch,
                                       input logic b, input logic e, input logic k);
    return {15'h0, sc, 3'b000, ch, b, e, k};
  endfunction

  // Observe the serial link using pre-edge values: count sclk rises and mux steps.
  always @(posedge clk) begin
    if (reset) begin
      idx = 0; rises = 0; sclk_prev = 1'b0; mux_prev = 3'd0;
    end else begin
      if (sclk && !sclk_prev) begin
        rises++;
        idx = (idx == 15) ? 0 : idx + 1;
      end
      sclk_prev = sclk;
      if (mux != mux_prev) stores++;
      mux_prev = mux;
    end
  end

  // Power board model: presents the current bit of the selected channel's frame MSB first.
  always @(negedge clk) data = frames[mux][15 - idx];

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string tag);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back(exp);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check_val(tag, readdata, exp_q.pop_front());
  endtask

  task automatic wait_stores(input int n, input int budget);
    int target = stores + n;
    int c = 0;
    while (stores < target && c < budget) begin @(negedge clk); c++; end
    check_val("store_wait", (stores >= target), 1);
  endtask

  task automatic wait_rises(input int total, input int budget);
    int c = 0;
    while (rises < total && c < budget) begin @(negedge clk); c++; end
    check_val("rise_wait", (rises >= total), 1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin @(negedge clk); c++; end
    check_val("idle_wait", busy, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chipselect = 1'b0; read = 1'b0; address = 4'd0;
    for (int n = 0; n < 8; n++) frames[n] = 16'h0123 + 16'(n);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_val("rst_busy", busy, 0);
    check_val("rst_mux", mux, 0);
    check_val("rst_sclk", sclk, 0);
    check_val("rst_error", error, 0);
    check_val("rst_kill", kill_sw, 0);
    rd(4'd8, 32'h0, "rst_status");
    rd(4'd3, 32'h0, "rst_chan3");

    // Scenario 1: full scan, start dropped during channel 7 which still completes
    start = 1'b1;
    wait_stores(7, 2000);
    start = 1'b0;
    wait_stores(1, 400);
    wait_idle(50);
    check_val("s1_mux", mux, 0);
    for (int n = 0; n < 8; n++) rd(4'(n), 32'h0123 + 32'(n), $sformatf("s1_chan%0d", n));
    rd(4'd8, stat(8'd1, 3'd0, 1'b0, 1'b0, KILL), "s1_status");
    rd(4'd9, 32'h0, "s1_addr9");
    rd(4'd15, 32'h0, "s1_addr15");

    // Scenario 2: bit 15 set on channel 3 -> sticky error, cleared by a status read
    frames[3] = 16'h8003;
    start = 1'b1;
    wait_stores(3, 1000);
    start = 1'b0;
    wait_stores(1, 400);
    wait_idle(50);
    check_val("s2_error_pin", error, 1);
    rd(4'd3, 32'h0000_8003, "s2_chan3");
    rd(4'd8, stat(8'd1, 3'd4, 1'b0, 1'b1, KILL), "s2_status_err");
    rd(4'd8, stat(8'd1, 3'd4, 1'b0, 1'b0, KILL), "s2_status_clr");
    check_val("s2_error_pin_clr", error, 0);
    frames[3] = 16'h0126;

    // Scenario 3: start drops during bit 5 of channel 2
    do_reset();
    start = 1'b1;
    wait_stores(2, 1000);
    wait_rises(32 + 5, 400);
    start = 1'b0;
    wait_stores(1, 400);
    wait_idle(50);
    check_val("s3_busy", busy, 0);
    check_val("s3_mux", mux, 3);
    rd(4'd2, 32'h0125, "s3_chan2");
    rd(4'd3, 32'h0, "s3_chan3");
    rd(4'd8, stat(8'd0, 3'd3, 1'b0, 1'b0, KILL), "s3_status");

    // Scenario 4: 1-cycle reset pulse during SHIFT of channel 4
    start = 1'b1;
    wait_stores(1, 400);
    wait_rises(64 + 3, 400);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_val("s4_mux", mux, 0);
    check_val("s4_busy", busy, 0);
    check_val("s4_kill", kill_sw, 0);
    for (int n = 0; n < 8; n++) rd(4'(n), 32'h0, $sformatf("s4_chan%0d", n));
    rd(4'd8, 32'h0, "s4_status");
    start = 1'b1;
    @(negedge clk);
    check_val("s4_restart_busy", busy, 1);
    check_val("s4_restart_mux", mux, 0);
    wait_stores(1, 400);
    start = 1'b0;
    wait_stores(1, 400);
    wait_idle(50);
    rd(4'd0, 32'h0123, "s4_chan0");
    rd(4'd4, 32'h0, "s4_chan4_discarded");
    check_val("s4_mux_end", mux, 2);

    // Scenario 5: undervoltage threshold on channel 0
    do_reset();
    frames[0] = 16'h09FF;
    start = 1'b1;
    wait_stores(1, 400);
    check_val("s5_kill_set", kill_sw, KILL);
    frames[0] = 16'h0A00;
    wait_stores(7, 3000);
    start = 1'b0;
    check_val("s5_kill_hold", kill_sw, KILL);
    wait_stores(1, 400);
    wait_idle(50);
    check_val("s5_kill_clr", kill_sw, 0);
    rd(4'd0, 32'h0A00, "s5_chan0");
    rd(4'd8, stat(8'd1, 3'd1, 1'b0, 1'b0, 1'b0), "s5_status");

    // Scenario 6: status read on the same clock as the STORE that sets error
    do_reset();
    frames[0] = 16'h8111;
    start = 1'b1;
    wait_rises(16, 400);
    begin
      int c = 0;
      while (sclk !== 1'b0 && c < 20) begin @(negedge clk); c++; end
    end
    check_val("s6_store_found", sclk, 0);
    check_val("s6_rdata_held", readdata, 32'h0);
    chipselect = 1'b1; read = 1'b1; address = 4'd8; start = 1'b0;
    exp_q.push_back(stat(8'd0, 3'd0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    check_val("s6_coincident_read", readdata, exp_q.pop_front());
    check_val("s6_error_wins", error, 1);
    check_val("s6_mux", mux, 1);
    wait_idle(50);
    rd(4'd8, stat(8'd0, 3'd1, 1'b0, 1'b1, KILL), "s6_status_err");
    rd(4'd8, stat(8'd0, 3'd1, 1'b0, 1'b0, KILL), "s6_status_clr");
    rd(4'd0, 32'h8111, "s6_chan0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
